// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing scheduler.
// Holds the default widths, the id-width helper and the result FIFO entry layout.
package mult_share_pkg;

  localparam int W1_DEF         = 8;
  localparam int W2_DEF         = 8;
  localparam int NREQ_DEF       = 4;
  localparam int MUL_LAT_DEF    = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = idw(NREQ_DEF);

  typedef struct packed {
    logic [IDW_DEF-1:0]       id;
    logic [W1_DEF+W2_DEF-1:0] sum;
  } fifo_entry_t;

endpackage

// File: rtl/mult_share_fifo.sv
// Synchronous result FIFO with occupancy count; the caller never pushes when full
// nor pops when empty.
module mult_share_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       push,
  input  logic [DW-1:0]              wr_data,
  input  logic                       pop,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters, with a
// tag pipe tracking in-flight ops and a credit-guarded result FIFO.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int W1         = W1_DEF,
  parameter int W2         = W2_DEF,
  parameter int NREQ       = NREQ_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int IDW        = idw(NREQ)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W1-1:0]   req_a,
  input  logic [NREQ*W2-1:0]   req_b,
  output logic [W1-1:0]        mul_a,
  output logic [W2-1:0]        mul_b,
  output logic                 mul_en,
  input  logic [W1+W2-1:0]     mul_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W1+W2-1:0]     rsp_sum,
  output logic                 busy
);

  localparam int SW = W1 + W2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [SW-1:0]  sum;
  } entry_t;

  // Handshakes: a transfer happens in any cycle where valid && ready are both high.
  // Ready may look at valid; valid must never look at ready. Credit uses only
  // registered counts, so rsp_ready has no combinational path to req_ready.
  logic [IDW-1:0]   ptr;
  logic [MUL_LAT-1:0] tag_vld;
  logic [IDW-1:0]   tag_id [MUL_LAT];
  logic [CW-1:0]    fifo_count;
  int               inflight;
  int               idx;
  logic             credit_ok;
  logic             grant;
  logic [IDW-1:0]   grant_id;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < MUL_LAT; i++) inflight = inflight + {31'b0, tag_vld[i]};
  end

  assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;

  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    idx      = 0;
    if (!sys_rst && credit_ok) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!grant && req_valid[IDW'(idx)]) begin
          grant    = 1'b1;
          grant_id = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
      mul_a = req_a[int'(grant_id)*W1 +: W1];
      mul_b = req_b[int'(grant_id)*W2 +: W2];
    end
  end

  // Holding en low is what clears the multiplier, so only reset may drop it.
  assign mul_en = !sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ptr     <= '0;
      tag_vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= grant;
      tag_id[0]  <= grant_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      if (grant) ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  assign push     = tag_vld[MUL_LAT-1];
  assign wr_entry = '{id: tag_id[MUL_LAT-1], sum: mul_sum};
  assign pop      = rsp_valid && rsp_ready;

  mult_share_fifo #(
    .DW    (IDW + SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign rsp_valid = fifo_count != '0;
  assign rsp_id    = head.id;
  assign rsp_sum   = head.sum;
  assign busy      = (|tag_vld) || rsp_valid;

endmodule
